// File: rtl/inv_key_sched_ctrl.sv
// AES-128 inverse key schedule sequencer: walks round keys 10..0 from the
// final round key, streams them over valid/ready and records them in a
// random-access key table.
`timescale 1ns/1ps
module inv_key_sched_ctrl #(
  parameter int unsigned NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] last_key,
  output logic         busy,
  output logic         done,
  output logic         key_valid,
  input  logic         key_ready,
  output logic [127:0] key_out,
  output logic [3:0]   key_round,
  output logic         sched_ready,
  input  logic [3:0]   rd_round,
  output logic [127:0] rd_key
);

  localparam int unsigned KEY_W     = 128;
  localparam int unsigned RND_W     = 4;
  localparam int unsigned TBL_DEPTH = NUM_ROUNDS + 1;

  // Forward AES S-box, byte 0x00 in the most significant position.
  localparam logic [2047:0] SBOX_FLAT = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    sub_byte = SBOX_FLAT[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [RND_W-1:0] r);
    case (r)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  // One inverse expansion step: round-r key -> round-(r-1) key.
  function automatic logic [KEY_W-1:0] inv_expand(input logic [KEY_W-1:0] k,
                                                  input logic [RND_W-1:0] r);
    logic [31:0] w0, w1, w2, w3, w4, w5, w6, w7, rot, sub;
    w4  = k[127:96];
    w5  = k[95:64];
    w6  = k[63:32];
    w7  = k[31:0];
    w3  = w6 ^ w7;
    w2  = w5 ^ w6;
    w1  = w4 ^ w5;
    rot = {w3[23:0], w3[31:24]};
    sub = {sub_byte(rot[31:24]), sub_byte(rot[23:16]),
           sub_byte(rot[15:8]),  sub_byte(rot[7:0])};
    w0  = w4 ^ sub ^ {rcon(r), 24'h000000};
    inv_expand = {w0, w1, w2, w3};
  endfunction

  state_e             state_q, state_d;
  logic [KEY_W-1:0]   cur_key_q, cur_key_d;
  logic [RND_W-1:0]   round_q, round_d;
  logic               key_valid_q, key_valid_d;
  logic [KEY_W-1:0]   key_out_q, key_out_d;
  logic [RND_W-1:0]   key_round_q, key_round_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               sched_ready_q, sched_ready_d;
  logic [KEY_W-1:0]   key_tbl_q [TBL_DEPTH];
  logic [KEY_W-1:0]   rd_key_q;
  logic [KEY_W-1:0]   rd_key_c;
  logic [KEY_W-1:0]   inv_key_c;
  logic               tbl_we_c;

  // Single shared expansion unit operating on the held key.
  assign inv_key_c = inv_expand(cur_key_q, round_q);

  // Next-state and registered-output logic.
  always_comb begin
    state_d       = state_q;
    cur_key_d     = cur_key_q;
    round_d       = round_q;
    key_valid_d   = key_valid_q;
    key_out_d     = key_out_q;
    key_round_d   = key_round_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    sched_ready_d = sched_ready_q;
    tbl_we_c      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy_d      = 1'b0;
        key_valid_d = 1'b0;
        if (start) begin
          cur_key_d     = last_key;
          round_d       = RND_W'(NUM_ROUNDS);
          sched_ready_d = 1'b0;
          busy_d        = 1'b1;
          state_d       = ST_EXPAND;
        end
      end
      ST_EXPAND: begin
        busy_d = 1'b1;
        if (!key_valid_q) begin
          // First cycle after load: present the held key.
          key_valid_d = 1'b1;
          key_out_d   = cur_key_q;
          key_round_d = round_q;
        end else if (key_ready) begin
          tbl_we_c = 1'b1;
          if (round_q == '0) begin
            key_valid_d = 1'b0;
            done_d      = 1'b1;
            state_d     = ST_DONE;
          end else begin
            cur_key_d   = inv_key_c;
            round_d     = round_q - RND_W'(1);
            key_out_d   = inv_key_c;
            key_round_d = round_q - RND_W'(1);
          end
        end
      end
      ST_DONE: begin
        busy_d        = 1'b0;
        sched_ready_d = 1'b1;
        state_d       = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cur_key_q     <= '0;
      round_q       <= '0;
      key_valid_q   <= 1'b0;
      key_out_q     <= '0;
      key_round_q   <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      sched_ready_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_key_q     <= cur_key_d;
      round_q       <= round_d;
      key_valid_q   <= key_valid_d;
      key_out_q     <= key_out_d;
      key_round_q   <= key_round_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      sched_ready_q <= sched_ready_d;
    end
  end

  // Key table: entry for the handed-off round is written on the handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < TBL_DEPTH; i++) key_tbl_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < TBL_DEPTH; i++) begin
        if (tbl_we_c && (round_q == RND_W'(i))) key_tbl_q[i] <= cur_key_q;
      end
    end
  end

  // Table read mux; out-of-range indices read as zero.
  always_comb begin
    rd_key_c = '0;
    for (int unsigned i = 0; i < TBL_DEPTH; i++) begin
      if (rd_round == RND_W'(i)) rd_key_c = key_tbl_q[i];
    end
  end

  // Registered read port.
  always_ff @(posedge clk) begin
    if (rst) rd_key_q <= '0;
    else     rd_key_q <= rd_key_c;
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign key_valid   = key_valid_q;
  assign key_out     = key_out_q;
  assign key_round   = key_round_q;
  assign sched_ready = sched_ready_q;
  assign rd_key      = rd_key_q;

endmodule
